sphere_pair_feeder: RTL and testbench

//  Upstream stage of dCollideSpheres. Buffers packed sphere-pair records
//  {x1,y1,z1,r1,x2,y2,z2,r2} (IEEE-754 single, 32b each) in a small FIFO.

---
 rtl/sphere_pkg.sv | 32 +++
 rtl/sphere_pair_feeder_pair_fifo.sv | 84 ++++++++
 rtl/sphere_pair_feeder.sv | 130 +++++++++++++
 tb/tb_sphere_pair_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sphere_pkg.sv
// Shared constants and types for the sphere-pair feeder: word/record widths,
// field positions inside a packed pair record, and the output-slot states.
package sphere_pkg;

  localparam int DATA_W = 32;
  localparam int PAIR_W = 8 * DATA_W;

  // Field LSB offsets, x1 sits in the most significant word
  localparam int X1_LSB = 7 * DATA_W;
  localparam int Y1_LSB = 6 * DATA_W;
  localparam int Z1_LSB = 5 * DATA_W;
  localparam int R1_LSB = 4 * DATA_W;
  localparam int X2_LSB = 3 * DATA_W;
  localparam int Y2_LSB = 2 * DATA_W;
  localparam int Z2_LSB = 1 * DATA_W;
  localparam int R2_LSB = 0;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } feeder_state_e;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/sphere_pair_feeder_pair_fifo.sv
// Synchronous FIFO of packed sphere-pair records with occupancy count and a
// registered ready flag that reflects the occupancy after each edge.
module pair_fifo #(
  parameter int W      = 256,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata,
  output logic              empty,
  output logic              ready,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0]      mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [ADDR_W:0]   level_nxt_s;
  logic              ready_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // ready_r is the gate, so a pop on a full edge cannot open room for a push
  assign empty     = (level_r == {(ADDR_W + 1){1'b0}});
  assign push_ok_s = push & ready_r & ~flush;
  assign pop_ok_s  = pop & ~empty & ~flush;
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;
  assign ready     = ready_r;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    level_nxt_s = level_r;
    if (flush) begin
      level_nxt_s = {(ADDR_W + 1){1'b0}};
    end else if (push_ok_s && !pop_ok_s) begin
      level_nxt_s = level_r + (ADDR_W + 1)'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      level_nxt_s = level_r - (ADDR_W + 1)'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and ready flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {(ADDR_W + 1){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {ADDR_W{1'b0}};
        rd_ptr_r <= {ADDR_W{1'b0}};
      end else begin
        if (push_ok_s) begin
          wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
        end
        if (pop_ok_s) begin
          rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
        end
      end
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s != FULL_LVL);
    end
  end

endmodule

// File: rtl/sphere_pair_feeder.sv
// Feeds buffered sphere pairs to the dCollideSpheres collider one at a time,
// advancing on each rising edge of dataFetch and counting starved fetches.
module sphere_pair_feeder
  import sphere_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PAIR_W-1:0] wr_pair,
  input  logic              dataFetch,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] z1,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] z2,
  output logic [DATA_W-1:0] r2,
  output logic              pair_valid,
  output logic [15:0]       pair_id,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       underrun
);

  feeder_state_e     state_r;
  logic              fetch_q_r;
  logic              first_load_r;
  logic [PAIR_W-1:0] pair_r;
  logic [PAIR_W-1:0] fifo_rdata_s;
  logic              fifo_empty_s;
  logic              fetch_rise_s;
  logic              pop_s;

  // fetch_q_r resets high so a request held across reset release is ignored
  assign fetch_rise_s = dataFetch & ~fetch_q_r;

  // Pop when the slot is free, or on a fetch rise while presenting
  always_comb begin
    pop_s = 1'b0;
    if (flush || fifo_empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pop_s = 1'b1;
    end else if (fetch_rise_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  pair_fifo #(
    .W      (PAIR_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (wr_valid),
    .pop   (pop_s),
    .wdata (wr_pair),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .ready (wr_ready),
    .level (level)
  );

  // Output slot state machine with its registered pair and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      fetch_q_r    <= 1'b1;
      first_load_r <= 1'b1;
      pair_r       <= {PAIR_W{1'b0}};
      pair_valid   <= 1'b0;
      pair_id      <= 16'd0;
      underrun     <= 16'd0;
    end else begin
      fetch_q_r <= dataFetch;
      if (flush) begin
        state_r    <= ST_IDLE;
        pair_valid <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (!fifo_empty_s) begin
              pair_r       <= fifo_rdata_s;
              pair_valid   <= 1'b1;
              pair_id      <= first_load_r ? 16'd0 : pair_id + 16'd1;
              first_load_r <= 1'b0;
              state_r      <= ST_PRESENT;
            end else if (fetch_rise_s) begin
              underrun <= sat_inc16(underrun);
            end
          end
          ST_PRESENT: begin
            if (fetch_rise_s) begin
              if (!fifo_empty_s) begin
                pair_r  <= fifo_rdata_s;
                pair_id <= pair_id + 16'd1;
              end else begin
                pair_valid <= 1'b0;
                state_r    <= ST_IDLE;
              end
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            pair_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x1 = pair_r[X1_LSB +: DATA_W];
  assign y1 = pair_r[Y1_LSB +: DATA_W];
  assign z1 = pair_r[Z1_LSB +: DATA_W];
  assign r1 = pair_r[R1_LSB +: DATA_W];
  assign x2 = pair_r[X2_LSB +: DATA_W];
  assign y2 = pair_r[Y2_LSB +: DATA_W];
  assign z2 = pair_r[Z2_LSB +: DATA_W];
  assign r2 = pair_r[R2_LSB +: DATA_W];

endmodule

// File: tb/tb_sphere_pair_feeder.sv
// Directed bench for sphere_pair_feeder: reset, latency, fill/backpressure,
// fetch advance and underrun, flush, and asynchronous reset mid-stream.
module tb_sphere_pair_feeder;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         wr_valid;
  logic         wr_ready;
  logic [255:0] wr_pair;
  logic         dataFetch;
  logic [31:0]  x1, y1, z1, r1, x2, y2, z2, r2;
  logic         pair_valid;
  logic [15:0]  pair_id;
  logic [3:0]   level;
  logic [15:0]  underrun;

  int checks;
  int errors;

  sphere_pair_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_pair    (wr_pair),
    .dataFetch  (dataFetch),
    .x1         (x1),
    .y1         (y1),
    .z1         (z1),
    .r1         (r1),
    .x2         (x2),
    .y2         (y2),
    .z2         (z2),
    .r2         (r2),
    .pair_valid (pair_valid),
    .pair_id    (pair_id),
    .level      (level),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of pair i carries k+1 in the top nibble and i below it
  function automatic logic [255:0] mk_pair(input int i);
    logic [255:0] p;
    for (int k = 0; k < 8; k++) begin
      p[(7 - k) * 32 +: 32] = {4'(k + 1), 28'(i)};
    end
    return p;
  endfunction

  logic [255:0] exp_p;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    wr_valid  = 1'b0;
    wr_pair   = 256'd0;
    dataFetch = 1'b1;

    // Held in reset
    tick();
    tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_pair_valid", 32'(pair_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_x1", x1, 32'd0);

    // Release with dataFetch high: no rise, no underrun
    rst = 1'b1;
    #1;
    check("rel_wr_ready_now", 32'(wr_ready), 32'd0);
    tick();
    check("rel_wr_ready_edge", 32'(wr_ready), 32'd1);
    check("rel_underrun", 32'(underrun), 32'd0);
    check("rel_pair_valid", 32'(pair_valid), 32'd0);
    dataFetch = 1'b0;
    tick();
    check("rel_underrun2", 32'(underrun), 32'd0);

    // First pair: two-edge latency to the collider outputs
    wr_pair  = {32'hBEFC475E, 32'h00000000, 32'h3FC00000, 32'h3F000000,
                32'h3EFC475E, 32'h00000000, 32'h3FC00000, 32'h3F000000};
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("lat_valid_edge1", 32'(pair_valid), 32'd0);
    check("lat_level_edge1", 32'(level), 32'd1);
    tick();
    check("p0_x1", x1, 32'hBEFC475E);
    check("p0_y1", y1, 32'h00000000);
    check("p0_z1", z1, 32'h3FC00000);
    check("p0_r1", r1, 32'h3F000000);
    check("p0_x2", x2, 32'h3EFC475E);
    check("p0_z2", z2, 32'h3FC00000);
    check("p0_r2", r2, 32'h3F000000);
    check("p0_valid", 32'(pair_valid), 32'd1);
    check("p0_id", 32'(pair_id), 32'd0);
    check("p0_level", 32'(level), 32'd0);

    // Fill the FIFO behind the presented pair
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1;
      wr_pair  = mk_pair(i);
      tick();
      if (i == 7) begin
        check("fill_level7", 32'(level), 32'd7);
        check("fill_ready7", 32'(wr_ready), 32'd1);
      end
    end
    check("full_level", 32'(level), 32'd8);
    check("full_ready", 32'(wr_ready), 32'd0);

    // Pop on a full edge while a write is offered: write not admitted
    wr_pair   = mk_pair(9);
    dataFetch = 1'b1;
    tick();
    exp_p = mk_pair(1);
    check("fullpop_level", 32'(level), 32'd7);
    check("fullpop_ready", 32'(wr_ready), 32'd1);
    check("fullpop_id", 32'(pair_id), 32'd1);
    check("fullpop_x1", x1, exp_p[255:224]);
    check("fullpop_r2", r2, exp_p[31:0]);
    wr_valid  = 1'b0;
    dataFetch = 1'b0;
    tick();
    check("hold_level", 32'(level), 32'd7);
    check("hold_id", 32'(pair_id), 32'd1);

    // Two fetch pulses drain to level 5
    for (int i = 2; i <= 3; i++) begin
      dataFetch = 1'b1;
      tick();
      dataFetch = 1'b0;
      tick();
      exp_p = mk_pair(i);
      check("drain_id", 32'(pair_id), 32'(i));
      check("drain_x1", x1, exp_p[255:224]);
    end
    check("drain_level", 32'(level), 32'd5);

    // Flush with five queued
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_p = mk_pair(3);
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(pair_valid), 32'd0);
    check("flush_id", 32'(pair_id), 32'd3);
    check("flush_x1_kept", x1, exp_p[255:224]);
    check("flush_ready", 32'(wr_ready), 32'd1);
    tick();
    check("flush_no_reload", 32'(pair_valid), 32'd0);

    wr_valid = 1'b1;
    wr_pair  = mk_pair(20);
    tick();
    wr_valid = 1'b0;
    tick();
    exp_p = mk_pair(20);
    check("postflush_id", 32'(pair_id), 32'd4);
    check("postflush_valid", 32'(pair_valid), 32'd1);
    check("postflush_y2", y2, exp_p[95:64]);

    // Two queued, four fetch pulses: advance, advance, drain, underrun
    for (int i = 21; i <= 22; i++) begin
      wr_valid = 1'b1;
      wr_pair  = mk_pair(i);
      tick();
    end
    wr_valid = 1'b0;
    check("q2_level", 32'(level), 32'd2);
    for (int i = 21; i <= 22; i++) begin
      dataFetch = 1'b1;
      tick();
      dataFetch = 1'b0;
      exp_p = mk_pair(i);
      check("adv_id", 32'(pair_id), 32'(i - 16));
      check("adv_z1", z1, exp_p[191:160]);
      tick();
    end
    dataFetch = 1'b1;
    tick();
    dataFetch = 1'b0;
    exp_p = mk_pair(22);
    check("drain3_valid", 32'(pair_valid), 32'd0);
    check("drain3_underrun", 32'(underrun), 32'd0);
    check("drain3_x1_kept", x1, exp_p[255:224]);
    tick();
    dataFetch = 1'b1;
    tick();
    dataFetch = 1'b0;
    check("starve_underrun", 32'(underrun), 32'd1);
    check("starve_valid", 32'(pair_valid), 32'd0);
    tick();

    // Mid-stream async reset between edges
    wr_valid = 1'b1;
    wr_pair  = mk_pair(23);
    tick();
    wr_valid = 1'b0;
    tick();
    check("pre_rst_id", 32'(pair_id), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    check("arst_x1", x1, 32'd0);
    check("arst_r2", r2, 32'd0);
    check("arst_valid", 32'(pair_valid), 32'd0);
    check("arst_id", 32'(pair_id), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_ready", 32'(wr_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
